// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - BCD capture and time-multiplexed 7-segment scan driver
//
// Captures the packed BCD vector from the binary-to-BCD converter whenever the
// completion strobe is high, holds it in a shadow register, and scans it onto a
// multiplexed 7-segment display one digit per SCAN_DIV-cycle slot. The first
// cycle of every slot is blanked to suppress ghosting during the digit change.
//
// Parameters:
//   numberOfDigits - number of BCD digits (matches the converter)
//   SCAN_DIV       - clock cycles per digit slot, >= 2
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   BinaryDecimal in   packed BCD, [0] is the least significant digit
//   to2_10Sum     in   converter done strobe; BinaryDecimal valid when high
//   seg           out  segments {g,f,e,d,c,b,a}, active-high, registered
//   dig_en        out  one-hot digit enable, active-high, registered
//   disp_valid    out  high once a value has been captured (scanning)
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (other than digit 0) show no segments
//   while keeping their dig_en slot.

module bcd_scan_display #(
  parameter int numberOfDigits = 3,
  parameter int SCAN_DIV       = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numberOfDigits-1:0][3:0] BinaryDecimal,
  input  logic                           to2_10Sum,
  output logic [6:0]                     seg,
  output logic [numberOfDigits-1:0]      dig_en,
  output logic                           disp_valid
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(numberOfDigits - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                           state_q, state_d;
  logic [numberOfDigits-1:0][3:0]   shadow_q, shadow_d;
  logic [PW-1:0]                    presc_q, presc_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [6:0]                       seg_q, seg_d;
  logic [numberOfDigits-1:0]        dig_en_q, dig_en_d;
  logic                             disp_valid_q, disp_valid_d;
  logic [numberOfDigits-1:0]        lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000; // non-BCD nibble shows a dash
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blanked while every
  // digit at or above it is zero. Digit 0 always displays.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = numberOfDigits - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (shadow_q[i] == 4'd0);
      lz_blank[i] = upper_zero & (i != 0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    seg_d        = '0;
    dig_en_d     = '0;

    // Capture is independent of state and never disturbs the scan position.
    if (to2_10Sum) shadow_d = BinaryDecimal;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        idx_d   = '0;
        if (to2_10Sum) state_d = SCAN;
      end
      SCAN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // Prescaler 0 is the anti-ghost blank cycle of the slot.
        if (presc_q != '0) begin
          dig_en_d[idx_q] = 1'b1;
          seg_d = lz_blank[idx_q] ? 7'b0000000 : decode(shadow_q[idx_q]);
        end
      end
      default: state_d = IDLE;
    endcase

    disp_valid_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= '0;
      dig_en_q     <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display

module tb_bcd_scan_display;

  localparam int ND = 3;
  localparam int SD = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ND-1:0][3:0]  bd = '0;
  logic                strobe = 1'b0;
  logic [6:0]          seg;
  logic [ND-1:0]       dig_en;
  logic                disp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: whether scanning, edges since the capture that started
  // scanning, and the currently held value.
  bit          m_scan    = 0;
  int          m_k       = 0;
  logic [11:0] m_val     = '0;
  logic [6:0]  exp_seg   = '0;
  logic [ND-1:0] exp_en  = '0;
  logic        exp_valid = 1'b0;

  bcd_scan_display #(.numberOfDigits(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .BinaryDecimal(bd), .to2_10Sum(strobe),
    .seg(seg), .dig_en(dig_en), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [16];
    tab[0] = 7'b0111111; tab[1] = 7'b0000110; tab[2] = 7'b1011011;
    tab[3] = 7'b1001111; tab[4] = 7'b1100110; tab[5] = 7'b1101101;
    tab[6] = 7'b1111101; tab[7] = 7'b0000111; tab[8] = 7'b1111111;
    tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) tab[i] = 7'b1000000;
    return tab[d];
  endfunction

  function automatic logic [6:0] digit_seg(input int pos, input logic [11:0] v);
    int d;
    d = int'((v >> (4 * pos)) & 12'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos >= 1 && (v >> (4 * pos)) == 0) return 7'b0000000;
`endif
    return seg_of(d);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int p;
    if (rst) begin
      m_scan = 0; m_k = 0; m_val = '0;
      exp_seg = '0; exp_en = '0; exp_valid = 1'b0;
    end else begin
      exp_seg = '0;
      exp_en  = '0;
      if (m_scan) begin
        m_k++;
        p = (m_k - 1) % (SD * ND);
        if (p % SD != 0) begin
          exp_en  = ND'(1) << (p / SD);
          exp_seg = digit_seg(p / SD, m_val);
        end
      end
      if (strobe) begin
        m_val = bd;
        if (!m_scan) begin m_scan = 1; m_k = 0; end
      end
      exp_valid = m_scan;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_dig_en", 32'(dig_en), 32'(exp_en));
    check("model_disp_valid", 32'(disp_valid), 32'(exp_valid));
  end

  task automatic wait_en(input logic [ND-1:0] want);
    int n;
    n = 0;
    while (dig_en !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_dig_en", 32'(dig_en), 32'(want));
  endtask

  task automatic pulse(input logic [11:0] v);
    bd = v;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin : stim
    logic [6:0] msd_seg;
`ifdef LEADING_ZERO_BLANK_EN
    msd_seg = 7'b0000000;
`else
    msd_seg = 7'b0111111;
`endif
    repeat (2) @(negedge clk);
    check("reset_seg", 32'(seg), 32'd0);
    check("reset_dig_en", 32'(dig_en), 32'd0);
    check("reset_valid", 32'(disp_valid), 32'd0);
    rst = 1'b0;

    repeat (50) @(negedge clk);
    check("idle_valid", 32'(disp_valid), 32'd0);
    check("idle_dig_en", 32'(dig_en), 32'd0);

    // {0,1,1}: capture edge N happens inside pulse
    pulse(12'h011);
    check("cap_valid", 32'(disp_valid), 32'd1);
    check("cap_dig_en", 32'(dig_en), 32'd0);
    @(negedge clk);                              // edge N+1: blank
    check("first_blank", 32'(dig_en), 32'd0);
    @(negedge clk);                              // edge N+2: digit 0
    check("d0_en", 32'(dig_en), 32'b001);
    check("d0_seg", 32'(seg), 32'b0000110);
    repeat (4) @(negedge clk);                   // edge N+6: digit 1
    check("d1_en", 32'(dig_en), 32'b010);
    check("d1_seg", 32'(seg), 32'b0000110);
    repeat (4) @(negedge clk);                   // edge N+10: digit 2
    check("d2_en", 32'(dig_en), 32'b100);
    check("d2_seg", 32'(seg), 32'(msd_seg));

    // Mid-slot update on digit 1: visible one edge after capture
    wait_en(3'b010);
    pulse(12'h987);
    @(negedge clk);
    check("mid_en", 32'(dig_en), 32'b010);
    check("mid_seg", 32'(seg), 32'b1111111);
    @(negedge clk);
    check("mid_boundary_blank", 32'(dig_en), 32'd0);

    // Non-BCD nibble on digit 1 shows a dash
    pulse(12'h0C5);
    @(negedge clk);
    wait_en(3'b010);
    check("dash_seg", 32'(seg), 32'b1000000);

    // Randomized strobes, values and back-to-back captures
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bd = 12'($urandom);
        if ($urandom_range(0, 2) == 0) bd[2] = 4'd0;
        if ($urandom_range(0, 3) == 0) bd[1] = 4'd0;
        strobe = 1'b1;
      end else begin
        strobe = 1'b0;
      end
      @(negedge clk);
    end
    strobe = 1'b0;

    // Asynchronous reset between edges while a digit is driven
    wait_en(3'b001);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_seg", 32'(seg), 32'd0);
    check("async_dig_en", 32'(dig_en), 32'd0);
    check("async_valid", 32'(disp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_valid", 32'(disp_valid), 32'd0);
    check("post_rst_seg", 32'(seg), 32'd0);

    // New capture after reset scans normally
    pulse(12'h123);
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
